// File: rtl/decode_pkg.sv
// Shared TinyRV1 decode types, encodings and control bundle
// for the scoreboarded decode stage.
package decode_pkg;

    typedef enum logic [3:0] {
        ADD, ADDI, MUL, LW, SW, JAL, JR, BNE, ILLEGAL
    } uop_t;

    typedef enum logic [1:0] {
        IMM_I, IMM_S, IMM_B, IMM_J
    } imm_type_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    typedef struct packed {
        uop_t      uop;
        logic      rs1_en;
        logic      rs2_en;
        logic      wen;
        imm_type_t imm_type;
        logic      op2_imm;
    } decode_ctrl_t;

    localparam decode_ctrl_t CTRL_ILLEGAL = '{
        uop: ILLEGAL, rs1_en: 1'b0, rs2_en: 1'b0,
        wen: 1'b0, imm_type: IMM_I, op2_imm: 1'b0
    };

    function automatic logic [31:0] imm_ext(
        input logic [31:0] i,
        input imm_type_t   t
    );
        logic [31:0] r;
        unique case (t)
            IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   r = {{19{i[31]}}, i[31], i[7],
                          i[30:25], i[11:8], 1'b0};
            IMM_J:   r = {{11{i[31]}}, i[31], i[19:12],
                          i[20], i[30:21], 1'b0};
            default: r = {{20{i[31]}}, i[31:20]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file, two read ports, N write ports; reads
// see same-cycle writes, x0 reads as zero.
module decode_regfile #(
    parameter int p_num_wb = 2
) (
    input  logic        clk,
    input  logic [4:0]  raddr0,
    output logic [31:0] rdata0,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        wen   [p_num_wb],
    input  logic [4:0]  waddr [p_num_wb],
    input  logic [31:0] wdata [p_num_wb]
);

    logic [31:0] mem [32];

    // Later ports override earlier ones on an address clash.
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_num_wb; i++) begin
            if (wen[i] && waddr[i] != 5'd0) begin
                mem[waddr[i]] <= wdata[i];
            end
        end
    end

    always_comb begin
        rdata0 = mem[raddr0];
        rdata1 = mem[raddr1];
        for (int i = 0; i < p_num_wb; i++) begin
            if (wen[i] && waddr[i] == raddr0) rdata0 = wdata[i];
            if (wen[i] && waddr[i] == raddr1) rdata1 = wdata[i];
        end
        if (raddr0 == 5'd0) rdata0 = '0;
        if (raddr1 == 5'd0) rdata1 = '0;
    end

endmodule

// File: rtl/decode_scoreboard.sv
// In-order TinyRV1 decode stage: instruction FIFO, decode,
// register read and pending-write scoreboard with hazard stall.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int p_addr_bits = 32,
    parameter int p_inst_bits = 32,
    parameter int p_buf_depth = 2,
    parameter int p_num_wb    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   F_val,
    output logic                   F_rdy,
    input  logic [p_inst_bits-1:0] F_inst,
    input  logic [p_addr_bits-1:0] F_pc,
    output logic                   X_val,
    input  logic                   X_rdy,
    output logic [p_addr_bits-1:0] X_pc,
    output uop_t                   X_uop,
    output logic [31:0]            X_op1,
    output logic [31:0]            X_op2,
    output logic [31:0]            X_imm,
    output logic [4:0]             X_waddr,
    output logic                   X_wen,
    input  logic                   W_val   [p_num_wb],
    input  logic [4:0]             W_waddr [p_num_wb],
    input  logic [31:0]            W_wdata [p_num_wb],
    input  logic                   squash
);

    localparam int PW = $clog2(p_buf_depth) + 1;
    localparam int IW = PW - 1;

    logic [PW-1:0]          wptr;
    logic [PW-1:0]          rptr;
    logic [p_addr_bits-1:0] buf_pc   [p_buf_depth];
    logic [p_inst_bits-1:0] buf_inst [p_buf_depth];
    logic                   empty;
    logic                   full;
    logic                   enq;
    logic                   issue;

    assign empty = (wptr == rptr);
    assign full  = (wptr[IW-1:0] == rptr[IW-1:0]) &&
                   (wptr[PW-1] != rptr[PW-1]);
    assign F_rdy = !full && !squash && !rst;
    assign enq   = F_val && F_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (squash) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq)   wptr <= wptr + PW'(1);
            if (issue) rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            buf_pc[wptr[IW-1:0]]   <= F_pc;
            buf_inst[wptr[IW-1:0]] <= F_inst;
        end
    end

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    assign inst   = buf_inst[rptr[IW-1:0]][31:0];
    assign X_pc   = buf_pc[rptr[IW-1:0]];
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign f7     = inst[31:25];

    logic is_add, is_mul, is_addi, is_lw;
    logic is_sw, is_jal, is_jr, is_bne;

    assign is_add  = opcode == OPC_OP && f3 == F3_ADD && f7 == F7_ADD;
    assign is_mul  = opcode == OPC_OP && f3 == F3_ADD && f7 == F7_MUL;
    assign is_addi = opcode == OPC_OPIMM && f3 == F3_ADD;
    assign is_lw   = opcode == OPC_LOAD && f3 == F3_W;
    assign is_sw   = opcode == OPC_STORE && f3 == F3_W;
    assign is_jal  = opcode == OPC_JAL;
    assign is_jr   = opcode == OPC_JALR && f3 == F3_ADD;
    assign is_bne  = opcode == OPC_BRANCH && f3 == F3_BNE;

    decode_ctrl_t ctrl;

    always_comb begin
        ctrl = CTRL_ILLEGAL;
        unique case (1'b1)
            is_add:  ctrl = '{ADD,  1'b1, 1'b1, 1'b1, IMM_I, 1'b0};
            is_mul:  ctrl = '{MUL,  1'b1, 1'b1, 1'b1, IMM_I, 1'b0};
            is_addi: ctrl = '{ADDI, 1'b1, 1'b0, 1'b1, IMM_I, 1'b1};
            is_lw:   ctrl = '{LW,   1'b1, 1'b0, 1'b1, IMM_I, 1'b1};
            is_sw:   ctrl = '{SW,   1'b1, 1'b1, 1'b0, IMM_S, 1'b0};
            is_jal:  ctrl = '{JAL,  1'b0, 1'b0, 1'b1, IMM_J, 1'b0};
            is_jr:   ctrl = '{JR,   1'b1, 1'b0, 1'b0, IMM_I, 1'b0};
            is_bne:  ctrl = '{BNE,  1'b1, 1'b1, 1'b0, IMM_B, 1'b0};
            default: ctrl = CTRL_ILLEGAL;
        endcase
    end

    logic [31:0] rdata1;
    logic [31:0] rdata2;

    decode_regfile #(
        .p_num_wb (p_num_wb)
    ) u_regfile (
        .clk    (clk),
        .raddr0 (rs1),
        .rdata0 (rdata1),
        .raddr1 (rs2),
        .rdata1 (rdata2),
        .wen    (W_val),
        .waddr  (W_waddr),
        .wdata  (W_wdata)
    );

    assign X_uop   = ctrl.uop;
    assign X_waddr = rd;
    assign X_wen   = ctrl.wen && rd != 5'd0;
    assign X_imm   = imm_ext(inst, ctrl.imm_type);
    assign X_op1   = rdata1;
    assign X_op2   = ctrl.op2_imm ? X_imm : rdata2;

    logic [31:0] pending;
    logic [31:0] pending_next;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        rd_hit;
    logic        hazard;

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        rd_hit  = 1'b0;
        for (int i = 0; i < p_num_wb; i++) begin
            if (W_val[i] && W_waddr[i] == rs1) rs1_hit = 1'b1;
            if (W_val[i] && W_waddr[i] == rs2) rs2_hit = 1'b1;
            if (W_val[i] && W_waddr[i] == rd)  rd_hit  = 1'b1;
        end
    end

    assign hazard = (ctrl.rs1_en && pending[rs1] && !rs1_hit) ||
                    (ctrl.rs2_en && pending[rs2] && !rs2_hit) ||
                    (X_wen && pending[rd] && !rd_hit);

    assign X_val = !empty && !hazard && !squash;
    assign issue = X_val && X_rdy;

    // Issue is applied after completions so a same-cycle set wins.
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < p_num_wb; i++) begin
            if (W_val[i]) pending_next[W_waddr[i]] = 1'b0;
        end
        if (issue && X_wen) pending_next[rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_next;
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed-vector bench for decode_scoreboard with
// hand-computed expectations.
module tb_decode_scoreboard;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        F_val = 1'b0;
    logic        F_rdy;
    logic [31:0] F_inst = '0;
    logic [31:0] F_pc = '0;
    logic        X_val;
    logic        X_rdy = 1'b0;
    logic [31:0] X_pc;
    uop_t        X_uop;
    logic [31:0] X_op1;
    logic [31:0] X_op2;
    logic [31:0] X_imm;
    logic [4:0]  X_waddr;
    logic        X_wen;
    logic        W_val   [2];
    logic [4:0]  W_waddr [2];
    logic [31:0] W_wdata [2];
    logic        squash = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    decode_scoreboard #(
        .p_addr_bits (32),
        .p_inst_bits (32),
        .p_buf_depth (2),
        .p_num_wb    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .F_val   (F_val),
        .F_rdy   (F_rdy),
        .F_inst  (F_inst),
        .F_pc    (F_pc),
        .X_val   (X_val),
        .X_rdy   (X_rdy),
        .X_pc    (X_pc),
        .X_uop   (X_uop),
        .X_op1   (X_op1),
        .X_op2   (X_op2),
        .X_imm   (X_imm),
        .X_waddr (X_waddr),
        .X_wen   (X_wen),
        .W_val   (W_val),
        .W_waddr (W_waddr),
        .W_wdata (W_wdata),
        .squash  (squash)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc,
                         input logic [31:0] ins);
        F_val  = 1'b1;
        F_pc   = pc;
        F_inst = ins;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            W_val[i]   = 1'b0;
            W_waddr[i] = '0;
            W_wdata[i] = '0;
        end

        #2;
        check("rst_f_rdy", 32'(F_rdy), 0);
        check("rst_x_val", 32'(X_val), 0);
        check("rst_pending", dut.pending, 0);
        cyc();
        rst = 1'b0;
        #1;
        check("post_rst_f_rdy", 32'(F_rdy), 1);

        // back-to-back independent addi
        X_rdy = 1'b1;
        offer(32'h100, 32'h00500093);
        #1;
        check("empty_no_bypass", 32'(X_val), 0);
        cyc();
        offer(32'h104, 32'h00700113);
        #1;
        check("b2b_val0", 32'(X_val), 1);
        check("b2b_pc0", X_pc, 32'h100);
        check("b2b_uop0", 32'(X_uop), 32'(ADDI));
        check("b2b_op2_0", X_op2, 5);
        check("b2b_waddr0", 32'(X_waddr), 1);
        check("b2b_wen0", 32'(X_wen), 1);
        cyc();
        F_val = 1'b0;
        #1;
        check("b2b_val1", 32'(X_val), 1);
        check("b2b_pc1", X_pc, 32'h104);
        check("b2b_op2_1", X_op2, 7);
        cyc();
        check("b2b_pending", dut.pending, 32'h6);
        check("b2b_drained", 32'(X_val), 0);

        // RAW stall then wakeup by completion
        offer(32'h108, 32'h001081B3);
        cyc();
        F_val = 1'b0;
        #1;
        check("raw_stall0", 32'(X_val), 0);
        cyc();
        check("raw_stall1", 32'(X_val), 0);
        W_val[0]   = 1'b1;
        W_waddr[0] = 5'd1;
        W_wdata[0] = 32'd5;
        #1;
        check("raw_wake_val", 32'(X_val), 1);
        check("raw_wake_uop", 32'(X_uop), 32'(ADD));
        check("raw_wake_op1", X_op1, 5);
        check("raw_wake_op2", X_op2, 5);
        cyc();
        W_val[0] = 1'b0;
        #1;
        check("raw_pending", dut.pending, 32'hC);

        // WAW stall, set wins over completion clear
        offer(32'h10C, 32'h00900213);
        cyc();
        F_val = 1'b0;
        #1;
        check("waw_setup_val", 32'(X_val), 1);
        offer(32'h110, 32'h02108233);
        cyc();
        F_val = 1'b0;
        #1;
        check("waw_stall", 32'(X_val), 0);
        W_val[1]   = 1'b1;
        W_waddr[1] = 5'd4;
        W_wdata[1] = 32'd9;
        #1;
        check("waw_wake_val", 32'(X_val), 1);
        check("waw_wake_uop", 32'(X_uop), 32'(MUL));
        check("waw_wake_op1", X_op1, 5);
        cyc();
        W_val[1] = 1'b0;
        #1;
        check("waw_pending", dut.pending, 32'h1C);

        // FIFO full with backpressure
        X_rdy = 1'b0;
        offer(32'h200, 32'h00100313);
        #1;
        check("full_rdy0", 32'(F_rdy), 1);
        cyc();
        offer(32'h204, 32'h00200393);
        #1;
        check("full_rdy1", 32'(F_rdy), 1);
        cyc();
        offer(32'h208, 32'h00300413);
        #1;
        check("full_rdy2", 32'(F_rdy), 0);
        check("full_head_pc", X_pc, 32'h200);
        cyc();
        check("stall_hold_pc", X_pc, 32'h200);
        check("stall_hold_op2", X_op2, 1);
        X_rdy = 1'b1;
        #1;
        check("full_no_x2f", 32'(F_rdy), 0);
        cyc();
        check("drain_rdy", 32'(F_rdy), 1);
        check("drain_pc1", X_pc, 32'h204);
        cyc();
        F_val = 1'b0;
        #1;
        check("drain_pc2", X_pc, 32'h208);
        check("drain_op2", X_op2, 3);
        cyc();
        check("drain_empty", 32'(X_val), 0);

        // squash with buffered entries and in-flight x5
        offer(32'h2FC, 32'h00400293);
        cyc();
        offer(32'h300, 32'h00100493);
        #1;
        check("sq_x5_pc", X_pc, 32'h2FC);
        cyc();
        X_rdy = 1'b0;
        offer(32'h304, 32'h00100513);
        cyc();
        offer(32'h308, 32'h00100593);
        squash     = 1'b1;
        X_rdy      = 1'b1;
        W_val[0]   = 1'b1;
        W_waddr[0] = 5'd5;
        W_wdata[0] = 32'd4;
        #1;
        check("sq_x_val", 32'(X_val), 0);
        check("sq_f_rdy", 32'(F_rdy), 0);
        cyc();
        squash   = 1'b0;
        W_val[0] = 1'b0;
        F_val    = 1'b0;
        #1;
        check("sq_after_val", 32'(X_val), 0);
        check("sq_after_rdy", 32'(F_rdy), 1);
        check("sq_pending", dut.pending, 32'h1DC);

        // illegal, jal/sw immediates, x0 destination
        offer(32'h400, 32'hFFFFFFFF);
        cyc();
        offer(32'h404, 32'h0080006F);
        #1;
        check("ill_val", 32'(X_val), 1);
        check("ill_uop", 32'(X_uop), 32'(ILLEGAL));
        check("ill_wen", 32'(X_wen), 0);
        cyc();
        offer(32'h408, 32'h00102623);
        #1;
        check("jal_uop", 32'(X_uop), 32'(JAL));
        check("jal_imm", X_imm, 8);
        check("jal_wen", 32'(X_wen), 0);
        cyc();
        offer(32'h40C, 32'h00100013);
        #1;
        check("sw_uop", 32'(X_uop), 32'(SW));
        check("sw_imm", X_imm, 12);
        check("sw_op2", X_op2, 5);
        cyc();
        F_val = 1'b0;
        #1;
        check("x0_val", 32'(X_val), 1);
        check("x0_wen", 32'(X_wen), 0);
        cyc();
        check("x0_pending", dut.pending, 32'h1DC);

        // async reset during a RAW stall
        offer(32'h500, 32'h000185B3);
        cyc();
        F_val = 1'b0;
        #1;
        check("ar_stall", 32'(X_val), 0);
        #1;
        rst = 1'b1;
        #1;
        check("ar_x_val", 32'(X_val), 0);
        check("ar_f_rdy", 32'(F_rdy), 0);
        check("ar_pending", dut.pending, 0);
        cyc();
        rst = 1'b0;
        #1;
        check("ar_fifo_empty", 32'(X_val), 0);
        check("ar_f_rdy_back", 32'(F_rdy), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
